// File: rtl/sec_down_timer.sv
// sec_down_timer: BCD MM:SS countdown timer (00:00 to 59:59).
// The count decrements once per prescaled one-second tick and borrows
// through the four digits. At 00:00 it pulses done and holds expired
// until the next load or reset.
//
// Ports:
//   clk                     system clock, rising edge
//   rst                     asynchronous active-low reset
//   load                    load the set_* digits (highest priority)
//   start / stop            level-sampled run / pause requests (stop wins)
//   set_m10/m1/s10/s1       digits to load; out-of-range values clamp
//   m10/m1/s10/s1           current count digits
//   running                 high while counting
//   tick                    one-cycle pulse on each decrement
//   done                    one-cycle pulse when the count reaches 00:00
//   expired                 sticky flag, cleared only by load or reset
module sec_down_timer #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CW       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] set_m10,
  input  logic [3:0] set_m1,
  input  logic [2:0] set_s10,
  input  logic [3:0] set_s1,
  output logic [2:0] m10,
  output logic [3:0] m1,
  output logic [2:0] s10,
  output logic [3:0] s1,
  output logic       running,
  output logic       tick,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  state_t        state, state_nx;
  logic [CW-1:0] presc, presc_nx;
  logic [2:0]    m10_nx, s10_nx;
  logic [3:0]    m1_nx, s1_nx;
  logic          tick_nx, done_nx;
  logic          count_zero, count_one;

  assign count_zero = (m10 == 3'd0) && (m1 == 4'd0) && (s10 == 3'd0) && (s1 == 4'd0);
  // The only count whose decrement yields 00:00.
  assign count_one  = (m10 == 3'd0) && (m1 == 4'd0) && (s10 == 3'd0) && (s1 == 4'd1);

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    m10_nx   = m10;
    m1_nx    = m1;
    s10_nx   = s10;
    s1_nx    = s1;
    tick_nx  = 1'b0;
    done_nx  = 1'b0;

    if (load) begin
      m10_nx   = (set_m10 > 3'd5) ? 3'd5 : set_m10;
      m1_nx    = (set_m1  > 4'd9) ? 4'd9 : set_m1;
      s10_nx   = (set_s10 > 3'd5) ? 3'd5 : set_s10;
      s1_nx    = (set_s1  > 4'd9) ? 4'd9 : set_s1;
      presc_nx = '0;
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!stop && start && !count_zero) state_nx = RUN;
        end
        RUN: begin
          // Stop on the tick edge leaves the prescaler at LAST, so the
          // decrement happens on the first cycle after resuming.
          if (stop) begin
            state_nx = PAUSE;
          end else if (presc == LAST) begin
            presc_nx = '0;
            tick_nx  = 1'b1;
            if (s1 != 4'd0) begin
              s1_nx = s1 - 4'd1;
            end else begin
              s1_nx = 4'd9;
              if (s10 != 3'd0) begin
                s10_nx = s10 - 3'd1;
              end else begin
                s10_nx = 3'd5;
                if (m1 != 4'd0) begin
                  m1_nx = m1 - 4'd1;
                end else begin
                  m1_nx  = 4'd9;
                  m10_nx = m10 - 3'd1;
                end
              end
            end
            if (count_one) begin
              done_nx  = 1'b1;
              state_nx = EXPIRED;
            end
          end else begin
            presc_nx = presc + CW'(1);
          end
        end
        PAUSE: begin
          if (!stop && start) state_nx = RUN;
        end
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      presc   <= '0;
      m10     <= '0;
      m1      <= '0;
      s10     <= '0;
      s1      <= '0;
      running <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      presc   <= presc_nx;
      m10     <= m10_nx;
      m1      <= m1_nx;
      s10     <= s10_nx;
      s1      <= s1_nx;
      running <= (state_nx == RUN);
      tick    <= tick_nx;
      done    <= done_nx;
      expired <= (state_nx == EXPIRED);
    end
  end

endmodule

// File: tb/tb_sec_down_timer.sv
// Bench for sec_down_timer with TICK_DIV=4. A seconds-based model predicts
// every output each cycle; directed steps add hand-computed literal checks.
module tb_sec_down_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [2:0] set_m10 = '0, set_s10 = '0;
  logic [3:0] set_m1 = '0, set_s1 = '0;
  logic [2:0] m10, s10;
  logic [3:0] m1, s1;
  logic       running, tick, done, expired;
  logic [13:0] dd;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  // Model: remaining seconds, cycles elapsed in the current second, flags.
  int m_secs = 0, m_phase = 0;
  bit m_run = 0, m_exp = 0, m_tick = 0, m_done = 0;

  sec_down_timer #(.TICK_DIV(TD), .CW(3)) dut (
    .clk(clk), .rst(rst), .load(load), .start(start), .stop(stop),
    .set_m10(set_m10), .set_m1(set_m1), .set_s10(set_s10), .set_s1(set_s1),
    .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .running(running), .tick(tick), .done(done), .expired(expired)
  );

  assign dd = {m10, m1, s10, s1};

  always #5 clk = ~clk;

  function automatic logic [13:0] digits_of(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [13:0] mmss(input int mm, input int ss);
    return digits_of(mm * 60 + ss);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_secs = 0; m_phase = 0; m_run = 0; m_exp = 0; m_tick = 0; m_done = 0;
    end else begin
      m_tick = 0;
      m_done = 0;
      if (load) begin
        m_secs = ((set_m10 > 5 ? 5 : int'(set_m10)) * 10 + (set_m1 > 9 ? 9 : int'(set_m1))) * 60
               + (set_s10 > 5 ? 5 : int'(set_s10)) * 10 + (set_s1 > 9 ? 9 : int'(set_s1));
        m_phase = 0;
        m_run = 0;
        m_exp = 0;
      end else if (m_exp) begin
        m_run = 0;
      end else if (m_run) begin
        if (stop) begin
          m_run = 0;
        end else begin
          m_phase++;
          if (m_phase == TD) begin
            m_phase = 0;
            m_secs--;
            m_tick = 1;
            if (m_secs == 0) begin
              m_done = 1;
              m_exp = 1;
              m_run = 0;
            end
          end
        end
      end else if (start && !stop && m_secs != 0) begin
        m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (chk_en) begin
      check("digits", int'(dd), int'(digits_of(m_secs)));
      check("running", int'(running), int'(m_run));
      check("tick", int'(tick), int'(m_tick));
      check("done", int'(done), int'(m_done));
      check("expired", int'(expired), int'(m_exp));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_load(input int a, input int b, input int c, input int d);
    set_m10 = 3'(a); set_m1 = 4'(b); set_s10 = 3'(c); set_s1 = 4'(d);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles until the given event output is seen high; 99 if it never is.
  task automatic wait_for(input bit want_done, output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((want_done ? done : tick) == 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, ticks, d0;
    rst = 1'b0;
    cyc(2);
    check("reset_digits", int'(dd), 0);
    check("reset_flags", int'({running, tick, done, expired}), 0);
    rst = 1'b1;
    chk_en = 1'b1;
    cyc(1);

    // 00:03 countdown to expiry
    do_load(0, 0, 0, 3);
    pulse_start();
    ticks = 0;
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      if (done) begin n = i; break; end
    end
    check("done_latency", n, 12);
    check("tick_count", ticks, 3);
    check("expired_at_zero", int'({running, expired}), 1);
    cyc(1);
    check("done_one_cycle", int'(done), 0);

    // start is ignored while expired; load leaves it
    pulse_start();
    cyc(3);
    check("expired_hold", int'({expired, running, dd}), 32'h8000);
    do_load(0, 0, 0, 5);
    check("reload_05", int'({expired, running, dd}), int'(mmss(0, 5)));

    // three-level borrow
    do_load(1, 0, 0, 0);
    pulse_start();
    wait_for(1'b0, n);
    check("first_tick_latency", n, 4);
    check("borrow_0959", int'(dd), int'(mmss(9, 59)));

    // pause and resume keep the partial second
    do_load(0, 1, 0, 0);
    pulse_start();
    cyc(2);
    stop = 1'b1;
    cyc(10);
    check("paused", int'(running), 0);
    stop = 1'b0;
    pulse_start();
    wait_for(1'b0, n);
    check("resume_latency", n, 2);
    check("resume_0059", int'(dd), int'(mmss(0, 59)));

    // clamping
    do_load(0, 0, 7, 12);
    check("clamp_sec", int'(dd), int'(mmss(0, 59)));
    do_load(7, 15, 0, 0);
    check("clamp_min", int'(dd), int'(mmss(59, 0)));

    // start at 00:00 is ignored
    do_load(0, 0, 0, 0);
    d0 = done_cnt;
    pulse_start();
    cyc(6);
    check("zero_start_running", int'(running), 0);
    check("zero_start_done", done_cnt - d0, 0);

    // start and stop together in IDLE act as stop
    do_load(0, 0, 0, 5);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    cyc(1);
    check("start_stop_idle", int'(running), 0);

    // load on the tick edge
    do_load(0, 0, 1, 0);
    pulse_start();
    cyc(3);
    do_load(0, 0, 0, 7);
    check("load_on_tick", int'({tick, running, dd}), int'(mmss(0, 7)));

    // stop on the tick edge, then resume ticks immediately
    do_load(0, 0, 1, 0);
    pulse_start();
    cyc(3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_on_tick", int'({tick, running, dd}), int'(mmss(0, 10)));
    pulse_start();
    wait_for(1'b0, n);
    check("stop_tick_resume", n, 1);
    check("stop_tick_0009", int'(dd), int'(mmss(0, 9)));

    // asynchronous reset mid-run at 00:41
    do_load(0, 0, 4, 2);
    pulse_start();
    wait_for(1'b0, n);
    check("pre_reset_0041", int'(dd), int'(mmss(0, 41)));
    cyc(1);
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    check("async_reset_digits", int'(dd), 0);
    check("async_reset_flags", int'({running, tick, done, expired}), 0);
    cyc(2);
    rst = 1'b1;
    cyc(8);
    check("reset_no_done", done_cnt - d0, 0);
    check("reset_idle", int'({running, dd}), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sec_down_timer.md
Name: sec_down_timer

Overview:
- BCD countdown timer (MM:SS, 00:00 to 59:59) for the second-display clock project.
- It counts down where the display counters count up. It decrements once per prescaled second tick and borrows through the four digits.
- It raises a done pulse and a sticky expired flag at 00:00.
- Its digit outputs feed the same 7-segment scan/decoder path as the up-counting clock chain.

Parameters:
- TICK_DIV, 1000: clk cycles per one-second tick. Range 2 to 2^26. Benches use 4.
- CW, 26: prescaler counter width. Must satisfy 2^CW >= TICK_DIV.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets immediately)
- load  in  1  synchronous load of set_* digits; highest priority
- start  in  1  level-sampled request to begin or resume the countdown
- stop  in  1  level-sampled request to pause the countdown
- set_m10  in  3  minutes tens digit to load (0-5)
- set_m1  in  4  minutes ones digit to load (0-9)
- set_s10  in  3  seconds tens digit to load (0-5)
- set_s1  in  4  seconds ones digit to load (0-9)
- m10  out  3  minutes tens digit
- m1  out  4  minutes ones digit
- s10  out  3  seconds tens digit
- s1  out  4  seconds ones digit
- running  out  1  high in the RUN state
- tick  out  1  one-cycle pulse on each decrement
- done  out  1  one-cycle pulse when the count reaches 00:00
- expired  out  1  sticky; high in the EXPIRED state

Behaviour:
- Reset (rst==0, asynchronous):
  - state goes to IDLE; prescaler is 0.
  - All digits are 0; running, tick, done and expired are all 0.
- States: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- Command priority per cycle: load > stop > start.
- load, in any state:
  - Digits are set from the set_* inputs on the next edge.
  - Clamping: a ones digit above 9 loads as 9; a tens digit above 5 loads as 5.
  - Prescaler clears to 0; state goes to IDLE; expired clears.
  - tick and done are not generated in that cycle.
- IDLE:
  - start with a nonzero count goes to RUN.
  - start at 00:00 is ignored and the state stays IDLE.
- RUN:
  - Prescaler increments each cycle. When it equals TICK_DIV-1 it wraps to 0, tick=1, and the count decrements.
  - stop goes to PAUSE and the prescaler value is held.
  - The first tick after entering RUN from IDLE arrives exactly TICK_DIV cycles after the start edge.
- PAUSE:
  - Digits and prescaler are frozen.
  - start resumes RUN from the held prescaler value. No extra or lost partial second.
- Decrement, mixed-radix with borrow:
  - s1 decrements. If s1==0, s1 becomes 9 and a borrow goes to s10.
  - If s10==0 on a borrow, s10 becomes 5 and a borrow goes to m1.
  - If m1==0 on a borrow, m1 becomes 9 and a borrow goes to m10.
  - m10 decrements. It is never required to underflow, because the count stops at 00:00.
- Zero detection:
  - When a decrement produces 00:00, in the same edge: done=1 for one cycle, expired=1, running=0, state goes to EXPIRED.
- EXPIRED:
  - Digits hold at 00:00; start and stop are ignored.
  - Only load or reset leaves this state.
- Simultaneous events:
  - load together with a tick edge: load wins and no decrement occurs.
  - stop together with a tick edge: stop wins, the state goes to PAUSE, no decrement occurs, and the prescaler holds TICK_DIV-1.
  - start and stop both high: treated as stop.
- Reset mid-count: all state clears asynchronously. No done pulse is emitted.

Test Plan:
- Reset, then load 00:03 and pulse start (TICK_DIV=4): tick every 4 cycles; display 00:02, 00:01, 00:00; done high for exactly 1 cycle; expired stays 1; running falls.
- Load 10:00 and run one tick: display 09:59 (three-level borrow chain).
- Load 01:00, run 2 cycles, stop for 10 cycles, then start: next tick comes 2 cycles after resume; display 00:59.
- Load with set_s1=12 and set_s10=7: display reads 00:59. Start with 00:00 loaded: running stays 0 and no done pulse.
- In EXPIRED, assert start: no change. Then load 00:05: expired=0, state IDLE, display 00:05.
- Assert rst low mid-run at 00:41: all outputs 0 immediately, before the next clk edge, with no done pulse. Also check load and stop each coinciding with the tick edge: no decrement occurs in either case.
